// File: rtl/fifo_read_stream.sv
// fifo_read_stream: drains an asynchronous FIFO read port into a valid/ready
// stream through a 2-entry in-order skid buffer. The FIFO read data is
// registered one cycle after each accepted pop and is always captured.
module fifo_read_stream #(
    parameter int unsigned DataSize   = 3,
    parameter int unsigned CountWidth = 16
) (
    input  logic                  Rclk,
    input  logic                  Rresetn,
    input  logic                  Enable,
    input  logic                  FifoEmpty,
    input  logic [DataSize-1:0]   FifoData,
    output logic                  Pop,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DataSize-1:0]   OutData,
    output logic [CountWidth-1:0] WordCount,
    output logic                  ErrOverflow
);

    localparam int unsigned OccWidth = 3;
    localparam int unsigned Depth    = 2;

    // Buffer occupancy doubles as the state encoding (value == held words)
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } buf_state_e;

    buf_state_e              r_state;
    buf_state_e              w_state_nxt;
    logic                    r_in_flight;
    logic                    r_head;
    logic                    r_tail;
    logic [DataSize-1:0]     r_mem [Depth];
    logic [CountWidth-1:0]   r_word_count;
    logic                    r_err_overflow;

    logic                    w_deq;
    logic                    w_cap;
    logic                    w_ovf;
    logic                    w_pop;
    logic [OccWidth-1:0]     w_occ;
    logic [OccWidth-1:0]     w_limit;

    // Handshake, capture and pop qualification
    always_comb begin
        w_deq   = (r_state != EMPTY) & OutReady;
        w_cap   = r_in_flight & ((r_state != FULL2) | w_deq);
        w_ovf   = r_in_flight & (r_state == FULL2) & ~w_deq;
        w_occ   = OccWidth'(r_state) + OccWidth'(r_in_flight);
        // Count + InFlight - Deq < 2, rewritten to avoid underflow
        w_limit = OccWidth'(2) + OccWidth'(w_deq);
        w_pop   = Rresetn & Enable & ~FifoEmpty & (w_occ < w_limit);
    end

    // Buffer occupancy next state: capture adds, dequeue removes, both cancel
    always_comb begin
        w_state_nxt = r_state;
        case ({w_cap, w_deq})
            2'b10: begin
                case (r_state)
                    EMPTY:   w_state_nxt = ONE;
                    ONE:     w_state_nxt = FULL2;
                    default: w_state_nxt = r_state;
                endcase
            end
            2'b01: begin
                case (r_state)
                    ONE:     w_state_nxt = EMPTY;
                    FULL2:   w_state_nxt = ONE;
                    default: w_state_nxt = r_state;
                endcase
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // Occupancy state register
    always_ff @(posedge Rclk or negedge Rresetn) begin
        if (!Rresetn) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pop accepted this cycle means FIFO data arrives next cycle
    always_ff @(posedge Rclk or negedge Rresetn) begin
        if (!Rresetn) begin
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= w_pop;
        end
    end

    // 1-bit wrap-around head/tail pointers
    always_ff @(posedge Rclk or negedge Rresetn) begin
        if (!Rresetn) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
        end else begin
            r_head <= r_head ^ w_deq;
            r_tail <= r_tail ^ w_cap;
        end
    end

    // Storage: write arriving FIFO data at the tail
    always_ff @(posedge Rclk or negedge Rresetn) begin
        if (!Rresetn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_cap) begin
            r_mem[r_tail] <= FifoData;
        end
    end

    // Delivered-word counter, wraps naturally
    always_ff @(posedge Rclk or negedge Rresetn) begin
        if (!Rresetn) begin
            r_word_count <= '0;
        end else if (w_deq) begin
            r_word_count <= r_word_count + CountWidth'(1);
        end
    end

    // Sticky overflow flag; the dropped word is simply not written
    always_ff @(posedge Rclk or negedge Rresetn) begin
        if (!Rresetn) begin
            r_err_overflow <= 1'b0;
        end else if (w_ovf) begin
            r_err_overflow <= 1'b1;
        end
    end

    assign Pop         = w_pop;
    assign OutValid    = (r_state != EMPTY);
    assign OutData     = r_mem[r_head];
    assign WordCount   = r_word_count;
    assign ErrOverflow = r_err_overflow;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: behavioural FIFO read port with registered data,
// scoreboard of expected stream words and a decoupled output monitor.
module tb_fifo_read_stream;

    localparam int unsigned DW = 3;
    localparam int unsigned CW = 4;

    logic          Rclk;
    logic          Rresetn;
    logic          Enable;
    logic          FifoEmpty;
    logic [DW-1:0] FifoData;
    logic          Pop;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] OutData;
    logic [CW-1:0] WordCount;
    logic          ErrOverflow;

    int n_checks;
    int n_errors;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];

    logic          pop_s;
    logic          ov_s;
    logic [DW-1:0] od_s;
    logic [CW-1:0] wc_s;
    logic          err_s;

    logic          mon_hold;
    logic [DW-1:0] mon_data;

    fifo_read_stream #(
        .DataSize   (DW),
        .CountWidth (CW)
    ) dut (
        .Rclk        (Rclk),
        .Rresetn     (Rresetn),
        .Enable      (Enable),
        .FifoEmpty   (FifoEmpty),
        .FifoData    (FifoData),
        .Pop         (Pop),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .OutData     (OutData),
        .WordCount   (WordCount),
        .ErrOverflow (ErrOverflow)
    );

    initial Rclk = 1'b0;
    always #5 Rclk = ~Rclk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: sample outputs mid-cycle, then model the FIFO's registered read
    task automatic tick();
        @(negedge Rclk);
        pop_s = Pop;
        ov_s  = OutValid;
        od_s  = OutData;
        wc_s  = WordCount;
        err_s = ErrOverflow;
        @(posedge Rclk);
        #1;
        if (pop_s && fifo_q.size() > 0) FifoData = fifo_q.pop_front();
        FifoEmpty = (fifo_q.size() == 0);
    endtask

    // Load n words with values cycling 1..7 starting at 'first'
    task automatic load(input int n, input int first, input bit score);
        logic [DW-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = DW'(((first - 1 + i) % 7) + 1);
            fifo_q.push_back(v);
            if (score) exp_q.push_back(v);
        end
        FifoEmpty = (fifo_q.size() == 0);
    endtask

    // Monitor: compares each delivered word against the scoreboard and
    // checks that a stalled word stays put
    initial begin
        mon_hold = 1'b0;
        mon_data = '0;
        forever begin
            @(negedge Rclk);
            if (!Rresetn) begin
                mon_hold = 1'b0;
            end else begin
                if (mon_hold) begin
                    check("hold_valid", int'(OutValid), 1);
                    check("hold_data", int'(OutData), int'(mon_data));
                end
                if (OutValid && OutReady) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_word: got %0d expected none (t=%0t)", OutData, $time);
                    end else begin
                        check("out_data", int'(OutData), int'(exp_q.pop_front()));
                    end
                    check("err_clear", int'(ErrOverflow), 0);
                end
                mon_hold = OutValid && !OutReady;
                mon_data = OutData;
            end
        end
    end

    int v_hist [20];
    int first_v;
    int total_v;
    int run_v;
    int best_v;
    int pops;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        Rresetn   = 1'b0;
        Enable    = 1'b1;
        OutReady  = 1'b1;
        FifoEmpty = 1'b1;
        FifoData  = '0;

        // Reset state with a word already waiting in the FIFO
        load(1, 5, 1'b1);
        tick();
        tick();
        check("rst_pop", int'(pop_s), 0);
        check("rst_valid", int'(ov_s), 0);
        check("rst_data", int'(od_s), 0);
        check("rst_wc", int'(wc_s), 0);
        check("rst_err", int'(err_s), 0);

        // Single word: Pop one cycle, OutValid two cycles later
        Rresetn = 1'b1;
        tick();
        check("single_pop", int'(pop_s), 1);
        tick();
        check("single_pop_once", int'(pop_s), 0);
        check("single_gap", int'(ov_s), 0);
        tick();
        check("single_valid", int'(ov_s), 1);
        check("single_data", int'(od_s), 5);
        tick();
        check("single_wc", int'(wc_s), 1);

        // Streaming 1..7 with no bubbles
        load(7, 1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            v_hist[i] = int'(ov_s);
        end
        total_v = 0;
        run_v   = 0;
        best_v  = 0;
        first_v = -1;
        for (int i = 0; i < 20; i++) begin
            total_v += v_hist[i];
            if (v_hist[i] != 0) begin
                if (first_v < 0) first_v = i;
                run_v++;
                if (run_v > best_v) best_v = run_v;
            end else begin
                run_v = 0;
            end
        end
        check("stream_total", total_v, 7);
        check("stream_run", best_v, 7);
        check("stream_wc", int'(wc_s), 8);

        // Backpressure: buffer fills to two, pops stop, head held
        OutReady = 1'b0;
        load(7, 1, 1'b1);
        repeat (10) tick();
        check("bp_pop", int'(pop_s), 0);
        check("bp_valid", int'(ov_s), 1);
        check("bp_data", int'(od_s), 1);
        check("bp_fifo_left", fifo_q.size(), 5);
        OutReady = 1'b1;
        repeat (20) tick();
        check("bp_wc", int'(wc_s), 15);
        check("bp_drained", exp_q.size(), 0);

        // Enable gating: the in-flight word still lands, no new pops
        load(2, 3, 1'b1);
        tick();
        check("gate_pop", int'(pop_s), 1);
        Enable = 1'b0;
        pops = 0;
        repeat (8) begin
            tick();
            pops += int'(pop_s);
        end
        check("gate_no_pop", pops, 0);
        check("gate_wc", int'(wc_s), 0);
        check("gate_fifo_left", fifo_q.size(), 1);
        Enable = 1'b1;
        repeat (6) tick();
        check("gate_wc2", int'(wc_s), 1);
        check("gate_drained", exp_q.size(), 0);

        // Reset mid-stream with a full buffer
        OutReady = 1'b0;
        load(7, 1, 1'b0);
        repeat (5) tick();
        check("mid_full_valid", int'(ov_s), 1);
        Rresetn = 1'b0;
        #1;
        check("mid_rst_valid", int'(OutValid), 0);
        check("mid_rst_wc", int'(WordCount), 0);
        check("mid_rst_err", int'(ErrOverflow), 0);
        check("mid_rst_pop", int'(Pop), 0);
        fifo_q.delete();
        FifoEmpty = 1'b1;
        tick();
        tick();
        Rresetn  = 1'b1;
        OutReady = 1'b1;

        // Resume and wrap the 4-bit counter: 17 words -> 1
        load(17, 1, 1'b1);
        repeat (30) tick();
        check("wrap_wc", int'(wc_s), 1);
        check("wrap_err", int'(err_s), 0);
        check("wrap_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_read_stream.md
FIFO_READ_STREAM -- requirements
Module: fifo_read_stream

Interface
REQ-001 SHALL have parameter DataSize, default 3: width of each data word, matching the asynchronous FIFO read data width.
REQ-002 SHALL have parameter CountWidth, default 16: width of the delivered-word counter.
REQ-003 SHALL have port Rclk  input  1  read-domain clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port Rresetn  input  1  reset, asynchronous assert, active-low; the block has one clock and this asynchronous active-low reset only.
REQ-005 SHALL have port Enable  input  1  permits new FIFO pops when high.
REQ-006 SHALL have port FifoEmpty  input  1  empty flag from the FIFO read side.
REQ-007 SHALL have port FifoData  input  DataSize  FIFO read data, valid the cycle after an accepted pop.
REQ-008 SHALL have port Pop  output  1  pop request to the FIFO.
REQ-009 SHALL have port OutValid  output  1  output stream word valid.
REQ-010 SHALL have port OutReady  input  1  downstream ready.
REQ-011 SHALL have port OutData  output  DataSize  output stream data.
REQ-012 SHALL have port WordCount  output  CountWidth  number of words delivered downstream.
REQ-013 SHALL have port ErrOverflow  output  1  sticky error: capture into full buffer.

Function
REQ-014 SHALL contain a 2-entry in-order skid buffer; Count (0..2) is the number of held words, and the buffer states are EMPTY (0), ONE (1), FULL2 (2).
REQ-015 SHALL register InFlight = Pop & !FifoEmpty each cycle; InFlight=1 means FifoData carries a new word this cycle.
REQ-016 SHALL drive Pop combinationally = Enable & !FifoEmpty & (Count + InFlight - Deq < 2), where Deq = OutValid & OutReady.
REQ-017 SHALL write FifoData to the buffer tail on every cycle with InFlight=1, one cycle after the pop, with no word dropped or duplicated.
REQ-018 SHALL drive OutValid = (Count != 0) and OutData = head entry; it SHALL never present FifoData combinationally.
REQ-019 SHALL keep OutData and OutValid stable while OutValid=1 and OutReady=0.
REQ-020 SHALL pop the head on Deq; a capture and a dequeue in the same cycle SHALL leave Count unchanged, with order preserved.
REQ-021 SHALL support sustained 1 word/cycle throughput when FifoEmpty=0, Enable=1 and OutReady=1 (steady state: Count=1, InFlight=1).
REQ-022 SHALL add a latency of 2 Rclk cycles from Pop asserted to OutValid, when Count=0 initially.
REQ-023 SHALL leave in-flight captures unaffected when Enable is deasserted; only new Pops are suppressed.
REQ-024 SHALL increment WordCount by 1 on each Deq, wrapping modulo 2^CountWidth.
REQ-025 SHALL set ErrOverflow when InFlight=1, Count=2 and Deq=0, hold it until reset, and drop the word; this is unreachable by design.
REQ-026 SHALL derive buffer pointers with 1-bit wrap-around head/tail indices.

Reset
REQ-027 SHALL on Rresetn=0 asynchronously clear Count, InFlight, the pointers, WordCount and ErrOverflow, and force Pop=0 and OutValid=0; OutData SHALL be 0.
REQ-028 SHALL discard buffered and in-flight words when reset asserts mid-operation; the first pop after release SHALL occur no earlier than the first Rclk edge with Rresetn=1.

Verification
REQ-029 SHALL pass a single word: FIFO holds 0x5, Enable=1, OutReady=1 -> Pop for 1 cycle, OutValid=1 with OutData=0x5 two cycles later, WordCount=1.
REQ-030 SHALL pass streaming: FIFO holds 1..7, OutReady=1 -> OutData 1..7 on consecutive cycles, no bubbles after the first word, WordCount=7.
REQ-031 SHALL pass backpressure: FIFO holds 1..7, OutReady=0 for 10 cycles -> Count=2, Pop=0, OutData held at 1; after release, 1..7 are delivered in order.
REQ-032 SHALL pass Enable gating: Enable drops the cycle after a Pop -> that word is still captured and delivered, and no further Pop occurs while Enable=0.
REQ-033 SHALL pass reset mid-stream: Rresetn pulsed low with Count=2 -> OutValid=0, WordCount=0 and ErrOverflow=0 immediately, and streaming resumes afterwards.
REQ-034 SHALL pass wrap-around: CountWidth=4 with 17 words delivered -> WordCount=1 and ErrOverflow=0 throughout.
